seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Passive monitor on a multiplexed, active-low 4-digit seven-segment display bus (segment lines plus digit anodes).
- Reconstructs the hex value shown, one nibble per digit, using the inverse of the team's hex-to-segment encoding.
- Filters scan glitches with a stability count, flags illegal patterns and signals complete frames.
- Sits beside the display driver; used for self-check/readback in the game and as a bench scoreboard helper.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (anode width)
STABLE_CNT, 4, consecutive identical samples needed before a digit commits (>=2)
TIMEOUT_CYC, 65535, cycles without any commit before all captured state is discarded

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
seg_n  in  7  segment lines, active-low, bit0=a..bit6=g (e.g. "0" = 1000000, "F" = 0001110, blank = 1111111)
an_n  in  NUM_DIGITS  digit select, active-low, legal only when exactly one bit is low
value  out  4*NUM_DIGITS  decoded nibbles, digit d at bits [4d+3:4d]
digit_valid  out  NUM_DIGITS  digit d holds a committed legal pattern (hex or blank)
blank  out  NUM_DIGITS  digit d committed as blank
frame_valid  out  1  one-cycle pulse: every digit committed since last pulse
pattern_err  out  1  one-cycle pulse: illegal pattern committed
err_digit  out  $clog2(NUM_DIGITS)  index of digit for latest pattern_err (held)
timeout  out  1  one-cycle pulse on timeout expiry

Behaviour:
- Reset: every output 0, sample register 0, stability counter 0, commit mask 0, timer 0, state IDLE. Reset mid-dwell discards progress; a pattern held through reset needs STABLE_CNT fresh samples.
- Input stage: {an_n, seg_n} registered every clock (1 sample register); all logic uses the sampled copy and the previous sample.
- Legal select = exactly one an_n bit low; d = its index.
- FSM states:
  - IDLE: sampled select illegal; counter 0. Legal select -> SETTLE, counter=1.
  - SETTLE: sample equals previous sample -> counter+1; on reaching STABLE_CNT, commit, -> HELD. Sample differs with legal select -> counter=1, stay. Illegal select -> IDLE.
  - HELD: sample unchanged -> stay, no further commits (exactly one commit per dwell). Sample changes: legal -> SETTLE with counter=1; illegal -> IDLE.
- Latency: pattern first sampled at edge k commits at edge k+STABLE_CNT-1; outputs updated after that edge (STABLE_CNT=4 -> 4th sampling edge).
- Commit decode:
  - One of the 16 hex patterns: value[d] = nibble, digit_valid[d]=1, blank[d]=0, mask[d]=1.
  - 1111111: value[d]=0, digit_valid[d]=1, blank[d]=1, mask[d]=1.
  - Any other pattern: value[d] unchanged, digit_valid[d]=0, blank[d]=0, mask[d]=0, pattern_err=1 for one cycle, err_digit=d.
- Frame: when a commit makes mask all-ones, frame_valid pulses on that same edge and mask clears on that edge.
- Timer counts cycles since the last commit (any kind). On reaching TIMEOUT_CYC: digit_valid, blank and mask clear, value kept, timeout pulses, timer restarts.
  - Commit and expiry on the same edge: commit wins, timer restarts, no timeout.
- At most one commit per cycle; the single-digit sample makes concurrent digit commits impossible.
- Re-commit of an already-masked digit before frame completion just updates that digit.

Decomposition:
- Package seg7_pkg:
  - Segment pattern constants SEG_0..SEG_F and SEG_BLANK, shared with the encoder.
  - FSM state enum {IDLE, SETTLE, HELD}.
- Sub-module seg7_pattern_decoder (combinational): seg_n(7) -> nibble(4), is_blank, is_legal.
- Top holds sample register, FSM, counter, mask, timer and output registers.

Test Plan:
- an_n=1110, seg_n=0110000 held 4 cycles after reset -> commit on 4th sampling edge: value[3:0]=3, digit_valid=0001, no frame_valid.
- Scan digits 0..3 with 0100100, 0011001, 0001000, 1111111, 6 cycles each -> frame_valid single pulse at digit 3 commit; value=0x0A42; blank=1000; digit_valid=1111.
- Digit 1 shows 1111110 for 5 cycles -> pattern_err pulse, err_digit=1, digit_valid[1]=0, value[7:4] unchanged, mask[1] cleared (no frame until digit 1 recommits).
- 3-cycle dwell, an_n=1100 (two low) or glitching segments each cycle -> no commit, no outputs change; a following 4-cycle clean dwell commits.
- TIMEOUT_CYC=20, one commit then an_n=1111 for 20 cycles -> timeout pulse, digit_valid=0000, value retained; commit landing on expiry cycle -> no timeout.
- rst asserted at 2nd cycle of a dwell, pattern kept -> all outputs 0; commit only after 4 post-reset sampling edges.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment patterns (bit0=a .. bit6=g)
// and the scan-monitor FSM state type.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HELD
   } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Inverse of the hex-to-segment encoder: maps an active-low pattern back to its nibble,
// flagging blank and anything that is neither a hex glyph nor blank.
module seg7_pattern_decoder
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] nibble,
   output logic       is_blank,
   output logic       is_legal
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
      nibble   = 4'h0;
      is_blank = 1'b0;
      is_legal = 1'b1;
      case (seg_n)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: is_blank = 1'b1;
         default:   is_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive monitor for a multiplexed active-low seven-segment bus: debounces each digit
// dwell, reconstructs the displayed hex value and reports frames, bad glyphs and timeouts.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int STABLE_CNT  = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [6:0]                    seg_n,
   input  logic [NUM_DIGITS-1:0]         an_n,
   output logic [4*NUM_DIGITS-1:0]       value,
   output logic [NUM_DIGITS-1:0]         digit_valid,
   output logic [NUM_DIGITS-1:0]         blank,
   output logic                          frame_valid,
   output logic                          pattern_err,
   output logic [$clog2(NUM_DIGITS)-1:0] err_digit,
   output logic                          timeout
);

   localparam int SW = NUM_DIGITS + 7;
   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int IW = $clog2(NUM_DIGITS);

   logic [SW-1:0]         cur;
   logic [SW-1:0]         smp_q;
   scan_state_t           state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0] mask_q, mask_set;
   logic [TW-1:0]         timer_q;
   logic                  sel_ok, same, commit;
   logic [IW-1:0]         sel_idx;
   logic [3:0]            nibble;
   logic                  is_blank, is_legal;

   // The bus value being sampled this edge is compared against the one sampled last edge,
   // so the first sample of a dwell already counts as 1.
   assign cur    = {an_n, seg_n};
   assign same   = (cur == smp_q);
   assign sel_ok = $onehot(~an_n);

   always_comb begin
      sel_idx  = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (!an_n[i]) sel_idx = IW'(i);
      mask_set          = mask_q;
      mask_set[sel_idx] = 1'b1;
   end

   seg7_pattern_decoder u_dec (
      .seg_n    (seg_n),
      .nibble   (nibble),
      .is_blank (is_blank),
      .is_legal (is_legal)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_ok) begin
               state_d = SETTLE;
               cnt_d   = CW'(1);
            end
         end
         SETTLE: begin
            if (!sel_ok) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!same) begin
               cnt_d = CW'(1);
            end else if (cnt_q == CW'(STABLE_CNT - 1)) begin
               commit  = 1'b1;
               state_d = HELD;
               cnt_d   = CW'(STABLE_CNT);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (!same) begin
               state_d = sel_ok ? SETTLE : IDLE;
               cnt_d   = sel_ok ? CW'(1) : '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         smp_q       <= '0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         mask_q      <= '0;
         timer_q     <= '0;
         value       <= '0;
         digit_valid <= '0;
         blank       <= '0;
         frame_valid <= 1'b0;
         pattern_err <= 1'b0;
         err_digit   <= '0;
         timeout     <= 1'b0;
      end else begin
         smp_q       <= cur;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_valid <= 1'b0;
         pattern_err <= 1'b0;
         timeout     <= 1'b0;
         if (commit) begin
            // A commit always restarts the timer, even on the cycle it would have expired.
            timer_q <= '0;
            if (is_legal) begin
               value[4*sel_idx +: 4] <= nibble;
               digit_valid[sel_idx]  <= 1'b1;
               blank[sel_idx]        <= is_blank;
               if (&mask_set) begin
                  frame_valid <= 1'b1;
                  mask_q      <= '0;
               end else begin
                  mask_q <= mask_set;
               end
            end else begin
               digit_valid[sel_idx] <= 1'b0;
               blank[sel_idx]       <= 1'b0;
               mask_q[sel_idx]      <= 1'b0;
               pattern_err          <= 1'b1;
               err_digit            <= sel_idx;
            end
         end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            timer_q     <= '0;
            digit_valid <= '0;
            blank       <= '0;
            mask_q      <= '0;
            timeout     <= 1'b1;
         end else begin
            timer_q <= timer_q + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: table-driven digit dwells through a scoreboard queue,
// plus hand-written latency, glitch, reset and timeout sequences.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_a, seg_b;
   logic [3:0]  an_a, an_b;
   logic [15:0] value_a, value_b;
   logic [3:0]  dv_a, dv_b, blank_a, blank_b;
   logic        frame_a, frame_b, perr_a, perr_b, to_a, to_b;
   logic [1:0]  ed_a, ed_b;

   always #5 clk = ~clk;

   seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(4), .TIMEOUT_CYC(65535)) dut_a (
      .clk(clk), .rst(rst), .seg_n(seg_a), .an_n(an_a), .value(value_a),
      .digit_valid(dv_a), .blank(blank_a), .frame_valid(frame_a),
      .pattern_err(perr_a), .err_digit(ed_a), .timeout(to_a)
   );

   seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(4), .TIMEOUT_CYC(20)) dut_b (
      .clk(clk), .rst(rst), .seg_n(seg_b), .an_n(an_b), .value(value_b),
      .digit_valid(dv_b), .blank(blank_b), .frame_valid(frame_b),
      .pattern_err(perr_b), .err_digit(ed_b), .timeout(to_b)
   );

   int total = 0;
   int bad   = 0;

   // Pulse counters, sampled shortly after each active edge.
   int frames_a = 0;
   int errs_a   = 0;
   int tos_b    = 0;

   always @(posedge clk) begin
      #1;
      if (frame_a === 1'b1) frames_a++;
      if (perr_a === 1'b1) errs_a++;
      if (to_b === 1'b1) tos_b++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_a  = an;
      seg_a = seg;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_b(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_b  = an;
      seg_b = seg;
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dv;
      logic [3:0]  bl;
      int          fr;
      int          er;
      logic [1:0]  ed;
   } exp_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      int         cyc;
      exp_t       e;
   } vec_t;

   vec_t tbl[$];
   exp_t sb[$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   f0, e0, t0;

      tbl.push_back('{4'b1110, 7'b0100100, 6, '{16'h0002, 4'b0001, 4'b0000, 0, 0, 2'd0}});
      tbl.push_back('{4'b1101, 7'b0011001, 6, '{16'h0042, 4'b0011, 4'b0000, 0, 0, 2'd0}});
      tbl.push_back('{4'b1011, 7'b0001000, 6, '{16'h0A42, 4'b0111, 4'b0000, 0, 0, 2'd0}});
      tbl.push_back('{4'b0111, 7'b1111111, 6, '{16'h0A42, 4'b1111, 4'b1000, 1, 0, 2'd0}});
      tbl.push_back('{4'b1101, 7'b1111110, 5, '{16'h0A42, 4'b1101, 4'b1000, 0, 1, 2'd1}});
      tbl.push_back('{4'b1110, 7'b1111001, 6, '{16'h0A41, 4'b1101, 4'b1000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1011, 7'b0001000, 6, '{16'h0A41, 4'b1101, 4'b1000, 0, 0, 2'd1}});
      tbl.push_back('{4'b0111, 7'b1111111, 6, '{16'h0A41, 4'b1101, 4'b1000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1101, 7'b0010010, 6, '{16'h0A51, 4'b1111, 4'b1000, 1, 0, 2'd1}});
      tbl.push_back('{4'b1100, 7'b0110000, 3, '{16'h0A51, 4'b1111, 4'b1000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1011, 7'b0000000, 3, '{16'h0A51, 4'b1111, 4'b1000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1110, 7'b0110000, 4, '{16'h0A53, 4'b1111, 4'b1000, 0, 0, 2'd1}});
      tbl.push_back('{4'b0111, 7'b1000110, 4, '{16'hCA53, 4'b1111, 4'b0000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1101, 7'b0100001, 4, '{16'hCAD3, 4'b1111, 4'b0000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1011, 7'b0000110, 4, '{16'hCED3, 4'b1111, 4'b0000, 1, 0, 2'd1}});
      tbl.push_back('{4'b1110, 7'b0001110, 4, '{16'hCEDF, 4'b1111, 4'b0000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1101, 7'b0000011, 4, '{16'hCEBF, 4'b1111, 4'b0000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1011, 7'b0000010, 4, '{16'hC6BF, 4'b1111, 4'b0000, 0, 0, 2'd1}});
      tbl.push_back('{4'b0111, 7'b1111000, 4, '{16'h76BF, 4'b1111, 4'b0000, 1, 0, 2'd1}});
      tbl.push_back('{4'b1110, 7'b0000000, 4, '{16'h76B8, 4'b1111, 4'b0000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1101, 7'b0010000, 4, '{16'h7698, 4'b1111, 4'b0000, 0, 0, 2'd1}});
      tbl.push_back('{4'b1011, 7'b1000000, 4, '{16'h7098, 4'b1111, 4'b0000, 0, 0, 2'd1}});
      tbl.push_back('{4'b0111, 7'b0110000, 4, '{16'h3098, 4'b1111, 4'b0000, 1, 0, 2'd1}});

      rst   = 1'b1;
      an_a  = 4'b1111;
      seg_a = SEG_BLANK;
      an_b  = 4'b1111;
      seg_b = SEG_BLANK;
      repeat (2) @(negedge clk);
      check("reset value", value_a, 16'h0);
      check("reset digit_valid", dv_a, 4'h0);
      check("reset blank", blank_a, 4'h0);
      check("reset pulses", {frame_a, perr_a, to_a}, 3'b000);
      check("reset err_digit", ed_a, 2'd0);
      rst = 1'b0;

      // First dwell after reset: nothing after 3 samples, commit on the 4th.
      f0 = frames_a;
      drive_a(4'b1110, SEG_3, 3);
      check("latency 3 samples digit_valid", dv_a, 4'b0000);
      drive_a(4'b1110, SEG_3, 1);
      check("latency 4 samples digit_valid", dv_a, 4'b0001);
      check("latency 4 samples value", value_a, 16'h0003);
      check("latency no frame", frames_a - f0, 0);

      foreach (tbl[i]) begin
         f0 = frames_a;
         e0 = errs_a;
         sb.push_back(tbl[i].e);
         drive_a(tbl[i].an, tbl[i].seg, tbl[i].cyc);
         e = sb.pop_front();
         check($sformatf("v%0d value", i), value_a, e.val);
         check($sformatf("v%0d digit_valid", i), dv_a, e.dv);
         check($sformatf("v%0d blank", i), blank_a, e.bl);
         check($sformatf("v%0d frame pulses", i), frames_a - f0, e.fr);
         check($sformatf("v%0d err pulses", i), errs_a - e0, e.er);
         check($sformatf("v%0d err_digit", i), ed_a, e.ed);
      end

      // Segments change every sample on a legal select: never settles.
      f0 = frames_a;
      e0 = errs_a;
      drive_a(4'b1110, SEG_1, 1);
      drive_a(4'b1110, 7'b0101010, 1);
      drive_a(4'b1110, SEG_1, 1);
      drive_a(4'b1110, SEG_8, 1);
      drive_a(4'b1110, 7'b0101010, 1);
      drive_a(4'b1110, SEG_8, 1);
      check("glitch value", value_a, 16'h3098);
      check("glitch digit_valid", dv_a, 4'b1111);
      check("glitch err pulses", errs_a - e0, 0);
      drive_a(4'b1110, SEG_1, 4);
      check("after glitch value", value_a, 16'h3091);
      check("after glitch frames", frames_a - f0, 0);

      // Reset on the 2nd cycle of a dwell with the pattern kept on the bus.
      drive_a(4'b1101, SEG_2, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid-dwell reset value", value_a, 16'h0);
      check("mid-dwell reset digit_valid", dv_a, 4'h0);
      check("mid-dwell reset err_digit", ed_a, 2'd0);
      drive_a(4'b1101, SEG_2, 3);
      check("post-reset 3 samples digit_valid", dv_a, 4'b0000);
      drive_a(4'b1101, SEG_2, 1);
      check("post-reset 4 samples digit_valid", dv_a, 4'b0010);
      check("post-reset 4 samples value", value_a, 16'h0020);

      // Timeout on the short-timer instance.
      drive_b(4'b1011, SEG_A, 4);
      check("timeout setup digit_valid", dv_b, 4'b0100);
      t0 = tos_b;
      drive_b(4'b1111, SEG_BLANK, 19);
      check("timeout 19 idle cycles pulses", tos_b - t0, 0);
      check("timeout 19 idle digit_valid", dv_b, 4'b0100);
      drive_b(4'b1111, SEG_BLANK, 1);
      check("timeout 20 idle pulses", tos_b - t0, 1);
      check("timeout pulse level", to_b, 1'b1);
      check("timeout digit_valid cleared", dv_b, 4'b0000);
      check("timeout value kept", value_b, 16'h0A00);

      // Commit lands on the edge where the restarted timer would expire.
      t0 = tos_b;
      drive_b(4'b1111, SEG_BLANK, 16);
      drive_b(4'b1110, SEG_5, 4);
      check("collision timeout pulses", tos_b - t0, 0);
      check("collision digit_valid", dv_b, 4'b0001);
      check("collision value", value_b, 16'h0A05);
      t0 = tos_b;
      drive_b(4'b1111, SEG_BLANK, 19);
      check("restart 19 idle pulses", tos_b - t0, 0);
      drive_b(4'b1111, SEG_BLANK, 1);
      check("restart 20 idle pulses", tos_b - t0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
